// File: rtl/text_vram_pkg.sv
// Shared definitions for the text-mode video RAM: default geometry and fill FSM states.
package text_vram_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned PLANES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vram_plane.sv
// One DATA_W x 2**ADDR_W plane: single write port, registered read port (read-before-write).
module vram_plane
  import text_vram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array is never reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/text_vram.sv
// Multi-plane text VRAM with masked writes, 1-cycle reads and a whole-memory fill engine.
// Optional read scrolling is enabled by defining TEXT_VRAM_SCROLL_EN.
module text_vram
  import text_vram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PLANES = PLANES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [PLANES*DATA_W-1:0] wr_data,
  input  logic [PLANES-1:0]        wr_mask,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
`ifdef TEXT_VRAM_SCROLL_EN
  input  logic [ADDR_W-1:0]        scroll_base,
`endif
  output logic [PLANES*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     clr_start,
  input  logic [PLANES*DATA_W-1:0] clr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned WORD_W = PLANES * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  fill_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [WORD_W-1:0] r_clr_data, w_clr_data_nxt;
  logic              r_busy, r_done, r_rd_valid;
  logic              w_fill_we;
  logic [ADDR_W-1:0] w_rd_addr_eff;

  // Fill FSM state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_clr_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_data <= w_clr_data_nxt;
      r_busy     <= (w_state_nxt == FILL);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_clr_data_nxt = r_clr_data;
    w_fill_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_state_nxt    = FILL;
          w_cnt_nxt      = '0;
          w_clr_data_nxt = clr_data;
        end
      end
      FILL: begin
        w_fill_we = 1'b1;
        // Counter parks at the last address instead of wrapping.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
    end
  end

`ifdef TEXT_VRAM_SCROLL_EN
  assign w_rd_addr_eff = rd_addr + scroll_base;
`else
  assign w_rd_addr_eff = rd_addr;
`endif

  // Fill owns the write port while active; host writes are dropped.
  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_we    = w_fill_we | (wr_en & wr_mask[p]);
    assign w_waddr = w_fill_we ? r_cnt : wr_addr;
    assign w_wdata = w_fill_we ? r_clr_data[p*DATA_W +: DATA_W]
                               : wr_data[p*DATA_W +: DATA_W];

    vram_plane #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_plane (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (rd_en),
      .i_raddr (w_rd_addr_eff),
      .o_rdata (rd_data[p*DATA_W +: DATA_W])
    );
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_text_vram.sv
// Randomized self-checking bench for text_vram against a word-array reference model.
module tb_text_vram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 13;
  localparam int unsigned PL    = 2;
  localparam int unsigned W     = PL * DW;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [PL-1:0] wr_mask = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] scroll_base = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          clr_start = 1'b0;
  logic [W-1:0]  clr_data = '0;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  text_vram #(.DATA_W(DW), .ADDR_W(AW), .PLANES(PL)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
`ifdef TEXT_VRAM_SCROLL_EN
    .scroll_base (scroll_base),
`endif
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .clr_start   (clr_start),
    .clr_data    (clr_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: word array, remaining-fill bookkeeping, expected outputs.
  logic [W-1:0] m_mem [DEPTH];
  bit           m_known [DEPTH];
  bit           m_fill = 1'b0;
  int unsigned  m_idx = 0;
  logic [W-1:0] m_val = '0;
  logic [W-1:0] exp_data = '0;
  bit           exp_known = 1'b1;
  bit           exp_valid = 1'b0;
  bit           exp_busy = 1'b0;
  bit           exp_done = 1'b0;

  always @(posedge clk or posedge reset) begin : mdl
    int unsigned a;
    bit prior_done;
    if (reset) begin
      exp_data = '0; exp_known = 1'b1; exp_valid = 1'b0;
      exp_busy = 1'b0; exp_done = 1'b0; m_fill = 1'b0; m_idx = 0;
    end else begin
      prior_done = exp_done;
      if (rd_en) begin
`ifdef TEXT_VRAM_SCROLL_EN
        a = (int'(rd_addr) + int'(scroll_base)) % DEPTH;
`else
        a = int'(rd_addr);
`endif
        exp_data  = m_mem[a];
        exp_known = m_known[a];
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      exp_done = 1'b0;
      if (m_fill) begin
        m_mem[m_idx] = m_val;
        m_known[m_idx] = 1'b1;
        if (m_idx == DEPTH - 1) begin
          m_fill = 1'b0;
          exp_done = 1'b1;
        end else begin
          m_idx++;
        end
      end else begin
        if (wr_en) begin
          for (int p = 0; p < int'(PL); p++)
            if (wr_mask[p]) m_mem[wr_addr][p*DW +: DW] = wr_data[p*DW +: DW];
          if (wr_mask == {PL{1'b1}}) m_known[wr_addr] = 1'b1;
        end
        if (clr_start && !prior_done) begin
          m_fill = 1'b1;
          m_idx  = 0;
          m_val  = clr_data;
        end
      end
      exp_busy = m_fill;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", 32'(rd_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (exp_known) check("rd_data", 32'(rd_data), 32'(exp_data));
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [PL-1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [W-1:0] d, output logic v);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data; v = rd_valid;
  endtask

  initial begin
    logic [W-1:0] d;
    logic v;
    int nb, nd;

    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #2;
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Whole-memory fill with a dropped write and ignored restart during busy.
    clr_start = 1'b1; clr_data = 16'h2020;
    nb = 0; nd = 0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      clr_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      if (busy) nb++;
      if (done) nd++;
      if (i == 10) begin wr_en = 1'b1; wr_addr = 13'h0005; wr_data = 16'h1111; wr_mask = 2'b11; end
      if (i == 20) begin rd_en = 1'b1; rd_addr = 13'h0000; end
      if (i == 30) begin clr_start = 1'b1; clr_data = 16'h0BAD; end
      if (i > 0 && !busy && !done) break;
    end
    check("fill_busy_cycles", 32'(nb), 32'd8192);
    check("fill_done_pulses", 32'(nd), 32'd1);
    rd(13'h0000, d, v); check("fill_0000", 32'(d), 32'h2020);
    rd(13'h1FFF, d, v); check("fill_1FFF", 32'(d), 32'h2020);
    rd(13'h0005, d, v); check("dropped_write", 32'(d), 32'h2020);

    // Full and masked writes.
    wr(13'h0010, 16'h4107, 2'b11);
    rd(13'h0010, d, v);
    check("write_full", 32'(d), 32'h4107);
    check("write_full_valid", 32'(v), 32'h1);
    wr(13'h0010, 16'hFF00, 2'b01);
    rd(13'h0010, d, v);
    check("write_masked", 32'(d), 32'h4100);

    // Read-before-write on a same-address collision.
    wr(13'h0020, 16'h5555, 2'b11);
    wr_en = 1'b1; wr_addr = 13'h0020; wr_data = 16'hAAAA; wr_mask = 2'b11;
    rd(13'h0020, d, v);
    wr_en = 1'b0;
    check("rbw_old", 32'(d), 32'h5555);
    rd(13'h0020, d, v);
    check("rbw_new", 32'(d), 32'hAAAA);

`ifdef TEXT_VRAM_SCROLL_EN
    wr(13'h0001, 16'h3C3C, 2'b11);
    scroll_base = 13'h1FFF;
    rd(13'h0002, d, v);
    check("scroll_wrap", 32'(d), 32'h3C3C);
    scroll_base = '0;
`endif

    // Randomized traffic over a small window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = W'($urandom);
      wr_mask = PL'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 15));
`ifdef TEXT_VRAM_SCROLL_EN
      scroll_base = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'(0);
`endif
      @(negedge clk);
    end
    wr_en = 1'b0; rd_en = 1'b0; scroll_base = '0;

    // Write plus fill start together, then asynchronous abort after 100 fill words.
    wr(13'h0063, 16'h4321, 2'b11);
    wr(13'h0064, 16'h1234, 2'b11);
    wr_en = 1'b1; wr_addr = 13'h0000; wr_data = 16'hBEEF; wr_mask = 2'b11;
    clr_start = 1'b1; clr_data = 16'h7E7E;
    @(negedge clk);
    wr_en = 1'b0; clr_start = 1'b0;
    rd_en = 1'b1; rd_addr = 13'h0200;
    repeat (100) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rd_valid", 32'(rd_valid), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd(13'h0063, d, v); check("abort_last_filled", 32'(d), 32'h7E7E);
    rd(13'h0064, d, v); check("abort_first_unfilled", 32'(d), 32'h1234);
    rd(13'h0000, d, v); check("fill_overwrites_write", 32'(d), 32'h7E7E);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/text_vram.md
TEXT_VRAM -- requirements
Module: text_vram

Interface
REQ-001 Parameter DATA_W, 8, bits per plane per word.
REQ-002 Parameter ADDR_W, 13, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter PLANES, 2, independent planes per word (e.g. character, colour); range 1..4.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  PLANES*DATA_W  write data; plane p at bits [p*DATA_W +: DATA_W].
REQ-009 wr_mask  input  PLANES  per-plane write enable.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_addr  input  ADDR_W  read address.
REQ-012 rd_data  output  PLANES*DATA_W  registered read data.
REQ-013 rd_valid  output  1  rd_data updated this cycle.
REQ-014 clr_start  input  1  start fill of whole memory.
REQ-015 clr_data  input  PLANES*DATA_W  fill value, sampled with clr_start.
REQ-016 busy  output  1  fill in progress.
REQ-017 done  output  1  one-cycle pulse at fill completion.

Function
REQ-018 Write: wr_en=1 and busy=0 at a rising edge SHALL write each plane p with wr_mask[p]=1; masked planes unchanged.
REQ-019 Read latency SHALL be 1 cycle: rd_en=1 at edge N -> rd_data and rd_valid=1 after edge N; rd_en=0 -> rd_valid=0, rd_data holds.
REQ-020 Same-address read and write in one cycle SHALL return old data (read-before-write).
REQ-021 Fill FSM states IDLE, FILL, DONE; IDLE->FILL on clr_start=1, latching clr_data, counter=0.
REQ-022 FILL SHALL write clr_data to all planes at counter, one word per cycle, counter 0..DEPTH-1 ascending; FILL->DONE after DEPTH-1 written.
REQ-023 DONE SHALL last one cycle with done=1, then IDLE; busy=1 exactly in FILL (DEPTH cycles).
REQ-024 While busy=1, wr_en SHALL be ignored (dropped, not queued); clr_start in FILL/DONE ignored.
REQ-025 Reads SHALL be served normally during FILL, returning current contents.
REQ-026 wr_en and clr_start together in IDLE: write performed that edge, fill starts; fill overwrites it.
REQ-027 Counter SHALL not wrap; fill ends at DEPTH-1.

Reset
REQ-028 reset=1 SHALL force rd_data=0, rd_valid=0, busy=0, done=0, state IDLE, counter 0 without waiting for clk.
REQ-029 Reset during FILL SHALL abort; written words keep fill value, rest unchanged; memory never reset.

Configuration
REQ-030 Macro TEXT_VRAM_SCROLL_EN defined: input scroll_base (ADDR_W) present; effective read address = (rd_addr + scroll_base) mod DEPTH, sampled with rd_en; writes and fill unaffected.
REQ-031 Macro undefined: no scroll_base port; effective read address = rd_addr.

Structure
REQ-032 Package text_vram_pkg SHALL hold fill state enum (IDLE, FILL, DONE) and default DATA_W/ADDR_W/PLANES.
REQ-033 Sub-module vram_plane (one DATA_W x DEPTH simple dual-port array, one write and one registered read port) SHALL be instantiated PLANES times; FSM, mask and scroll logic in text_vram.

Verification (PLANES=2, DATA_W=8, ADDR_W=13)
REQ-034 Write 0x0010 data 0x4107 mask 2'b11, read 0x0010 next cycle -> rd_data=0x4107, rd_valid=1 one cycle later.
REQ-035 Then write 0x0010 data 0xFF00 mask 2'b01, read -> 0x4100.
REQ-036 clr_start with clr_data 0x2020 -> busy high 8192 cycles, done one pulse, reads of 0x0000/0x1FFF -> 0x2020; wr_en during busy to 0x0005 data 0x1111 -> 0x2020 afterwards.
REQ-037 reset asserted mid-clock after 100 FILL cycles -> busy=0, rd_valid=0 immediately; 0x0063 reads fill value, 0x0064 old data.
REQ-038 Same-cycle write 0x0020 data 0xAAAA over 0x5555 with read 0x0020 -> 0x5555, next read 0xAAAA.
REQ-039 With TEXT_VRAM_SCROLL_EN, scroll_base=0x1FFF, rd_addr=0x0002 -> contents of 0x0001.
